axi4_wr_slave: RTL
==================

Name: axi4_wr_slave

Overview:
AXI4 write-path responder: the subordinate end of the AW/W/B channels of the team's AXI4 bus. Accepts one write burst at a time, generates per-beat byte addresses (FIXED/INCR/WRAP), issues registered native write strobes to a downstream RAM/register file, and returns a single B response with echoed ID. It is the counterpart of the testbench/master driving axi4_if write channels; a read-path twin reuses its address generator.

Parameters:
ADDR_WIDTH, 32, address bus width in bits
DATA_WIDTH, 32, data bus width in bits (8/16/32/64/128)
ID_WIDTH, 8, transaction ID width
STRB_WIDTH, DATA_WIDTH/8, write strobe width (derived, not overridden)

Ports:
clock  input  1  single clock, all logic rising-edge
ARESET  input  1  asynchronous, active-high reset
AWID / AWADDR / AWLEN / AWSIZE / AWBURST  input  ID_WIDTH / ADDR_WIDTH / 8 / 3 / 2  write address channel
AWVALID  input  1  address valid
AWREADY  output  1  address ready
WDATA / WSTRB / WLAST  input  DATA_WIDTH / STRB_WIDTH / 1  write data channel
WVALID  input  1  data valid
WREADY  output  1  data ready
BID / BRESP  output  ID_WIDTH / 2  write response
BVALID  output  1  response valid
BREADY  input  1  response ready
mem_we  output  1  one-cycle write pulse to backing store
mem_addr  output  ADDR_WIDTH  byte address of beat
mem_wdata  output  DATA_WIDTH  beat data
mem_wstrb  output  STRB_WIDTH  beat byte enables
AWLOCK/AWCACHE/AWPROT/AWQOS are not ports; the block ignores them.

Behaviour:
- Reset (async assert, sync release): state IDLE; AWREADY=1, WREADY=0, BVALID=0, BID=0, BRESP=0, mem_we=0, mem_addr/wdata/wstrb=0. Reset mid-burst aborts: no further mem_we, no B response.
- FSM IDLE -> DATA -> RESP -> IDLE; one burst outstanding.
- IDLE: AWREADY=1, WREADY=0. On AWVALID&AWREADY latch ID, ADDR, LEN, SIZE, BURST; beat counter=0; err=0; next DATA. W beats arriving in IDLE are not accepted.
- DATA: AWREADY=0, WREADY=1. Each WVALID&WREADY beat: next cycle mem_we=1 with current address, WDATA, WSTRB (latency 1); counter++; address advances.
- Burst end: beat where counter==LEN or WLAST=1, whichever first. WLAST early (counter<LEN) or missing on beat LEN -> err=1. Next state RESP; WREADY drops the cycle after last beat.
- Illegal bursts, detected at AW handshake, set err=1 and suppress all mem_we for the burst while still consuming LEN+1 beats: AWSIZE > log2(STRB_WIDTH); AWBURST=3; WRAP with LEN not in {1,3,7,15}.
- RESP: BVALID=1 first cycle after last W handshake; BID=latched ID; BRESP=2'b10 (SLVERR) if err else 2'b00 (OKAY). Hold stable until BREADY; on BVALID&BREADY -> IDLE, AWREADY=1 next cycle. BREADY high early has no effect.
- Address arithmetic, bytes = 1<<SIZE:
  - FIXED: every beat uses AWADDR.
  - INCR: beat0 = AWADDR (unaligned allowed; WSTRB passed unmodified); beat n = (AWADDR aligned down to bytes) + n*bytes, modulo 2^ADDR_WIDTH. No 4 KB check.
  - WRAP: container = (LEN+1)*bytes; lower = AWADDR aligned down to container; addr+bytes wraps to lower at lower+container.
- Minimum burst cycle: AW 1, W LEN+1, B 1; back-to-back bursts legal with no extra idle.

Decomposition:
- Package axi4_pkg: burst_t enum (FIXED=2'b00, INCR=2'b01, WRAP=2'b10), resp_t (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11), wr_state_t (IDLE, DATA, RESP).
- Sub-module axi4_burst_addr_gen: combinational next-address from (addr, size, len, burst), reused by the future read responder.

Test Plan:
- INCR: AWADDR=0x100, LEN=3, SIZE=2, WLAST on beat 3, BREADY=1 -> mem_we at 0x100/0x104/0x108/0x10C, BID echoes AWID=0x5A, BRESP=OKAY.
- WRAP: AWADDR=0x38, LEN=3, SIZE=2 -> mem_addr 0x38, 0x3C, 0x30, 0x34; OKAY.
- FIXED: AWADDR=0x20, LEN=2, WSTRB=0x1/0x2/0x4 -> three writes all at 0x20 with those strobes.
- Errors: WLAST on beat 1 of LEN=3 -> burst ends, SLVERR. AWSIZE=3 with DATA_WIDTH=32 -> 4 beats consumed, zero mem_we, SLVERR.
- BREADY held low 5 cycles -> BVALID/BID/BRESP stable, AWREADY=0 throughout; AWREADY=1 cycle after handshake.
- Assert ARESET during beat 2 of LEN=7 -> outputs return to reset values immediately; no B response; next burst completes normally.

Source files
------------

// File: rtl/axi4_pkg.sv
// Shared AXI4 types for the write responder and its burst address generator.
// Holds the burst, response and write-FSM encodings used across the slice.
package axi4_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } burst_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        RESP
    } wr_state_t;

endpackage

// File: rtl/axi4_wr_slave_if.sv
// AXI4 write-channel bundle (AW, W, B).
// Ports (by modport):
//   slave  : receives AW*/W*/BREADY, drives AWREADY/WREADY/BID/BRESP/BVALID
//   master : the mirror image, used by whatever drives the write path
interface axi4_wr_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 8
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ID_WIDTH-1:0]   AWID;
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic [7:0]            AWLEN;
    logic [2:0]            AWSIZE;
    logic [1:0]            AWBURST;
    logic                  AWVALID;
    logic                  AWREADY;

    logic [DATA_WIDTH-1:0] WDATA;
    logic [STRB_WIDTH-1:0] WSTRB;
    logic                  WLAST;
    logic                  WVALID;
    logic                  WREADY;

    logic [ID_WIDTH-1:0]   BID;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

endinterface

// File: rtl/axi4_burst_addr_gen.sv
// Combinational AXI4 next-beat address from the current beat address.
// Ports:
//   addr     : byte address of the current beat
//   size     : AxSIZE, beat is 1<<size bytes
//   len      : AxLEN, burst is len+1 beats (sets the WRAP container)
//   burst    : AxBURST encoding (FIXED/INCR/WRAP)
//   nextAddr : byte address of the following beat
// Shared between the write responder and the read responder.
module axi4_burst_addr_gen
    import axi4_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            size,
    input  logic [7:0]            len,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] nextAddr
);

    logic [ADDR_WIDTH-1:0] bytes;
    logic [ADDR_WIDTH-1:0] container;
    logic [ADDR_WIDTH-1:0] incrAddr;
    logic [ADDR_WIDTH-1:0] lower;

    // INCR steps from the size-aligned address, so an unaligned first beat
    // snaps onto the beat grid from the second beat onward. WRAP keeps the
    // offset inside a power-of-two container; for illegal WRAP lengths the
    // result is meaningless but those bursts never write.
    always_comb begin
        bytes     = ADDR_WIDTH'(1) << size;
        container = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) * bytes;
        incrAddr  = (addr & ~(bytes - ADDR_WIDTH'(1))) + bytes;
        lower     = addr & ~(container - ADDR_WIDTH'(1));
        nextAddr  = addr;
        case (burst)
            FIXED:   nextAddr = addr;
            INCR:    nextAddr = incrAddr;
            WRAP:    nextAddr = lower | (incrAddr & (container - ADDR_WIDTH'(1)));
            default: nextAddr = addr;
        endcase
    end

endmodule

// File: rtl/axi4_wr_slave.sv
// AXI4 write-path responder: one burst at a time over AW/W/B.
// Ports:
//   clock, ARESET : rising-edge clock, async active-high reset
//   axi           : AW/W/B channels (slave modport)
//   mem_we        : one-cycle write pulse, one cycle after each accepted beat
//   mem_addr      : byte address of that beat
//   mem_wdata     : beat data
//   mem_wstrb     : beat byte enables, passed through unmodified
module axi4_wr_slave
    import axi4_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 8
) (
    input  logic                         clock,
    input  logic                         ARESET,
    axi4_wr_slave_if.slave               axi,
    output logic                         mem_we,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic [DATA_WIDTH-1:0]        mem_wdata,
    output logic [(DATA_WIDTH/8)-1:0]    mem_wstrb
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int MAX_SIZE   = $clog2(STRB_WIDTH);

    wr_state_t             state;
    wr_state_t             nextState;

    logic [ID_WIDTH-1:0]   idReg;
    logic [ADDR_WIDTH-1:0] addrReg;
    logic [7:0]            lenReg;
    logic [2:0]            sizeReg;
    logic [1:0]            burstReg;
    logic [7:0]            beatCnt;
    logic                  errReg;
    logic                  suppressReg;

    logic                  awHs;
    logic                  wHs;
    logic                  bHs;
    logic                  countDone;
    logic                  lastBeat;
    logic                  illegalBurst;
    logic [ADDR_WIDTH-1:0] nextAddr;

    assign awHs      = axi.AWVALID && axi.AWREADY;
    assign wHs       = axi.WVALID && axi.WREADY;
    assign bHs       = axi.BVALID && axi.BREADY;
    assign countDone = (beatCnt == lenReg);
    assign lastBeat  = countDone || axi.WLAST;

    // Bursts this responder cannot honour: beat wider than the bus, the
    // reserved burst type, or a WRAP whose beat count is not 2/4/8/16.
    always_comb begin
        illegalBurst = 1'b0;
        if (axi.AWSIZE > 3'(MAX_SIZE)) begin
            illegalBurst = 1'b1;
        end
        if (axi.AWBURST == 2'b11) begin
            illegalBurst = 1'b1;
        end
        if (axi.AWBURST == WRAP) begin
            case (axi.AWLEN)
                8'd1, 8'd3, 8'd7, 8'd15: ;
                default: illegalBurst = 1'b1;
            endcase
        end
    end

    axi4_burst_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_addr_gen (
        .addr    (addrReg),
        .size    (sizeReg),
        .len     (lenReg),
        .burst   (burstReg),
        .nextAddr(nextAddr)
    );

    // State register.
    always_ff @(posedge clock or posedge ARESET) begin
        if (ARESET) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next state: one burst in flight, the burst ends on whichever of the
    // counted last beat or WLAST arrives first.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (awHs) nextState = DATA;
            DATA:    if (wHs && lastBeat) nextState = RESP;
            RESP:    if (bHs) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Channel outputs are pure functions of the state and latched burst.
    always_comb begin
        axi.AWREADY = (state == IDLE);
        axi.WREADY  = (state == DATA);
        axi.BVALID  = (state == RESP);
        axi.BID     = idReg;
        axi.BRESP   = errReg ? SLVERR : OKAY;
    end

    // Burst context and the registered memory write port. An illegal burst
    // still walks through its beats but never raises mem_we.
    always_ff @(posedge clock or posedge ARESET) begin
        if (ARESET) begin
            idReg       <= '0;
            addrReg     <= '0;
            lenReg      <= '0;
            sizeReg     <= '0;
            burstReg    <= '0;
            beatCnt     <= '0;
            errReg      <= 1'b0;
            suppressReg <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wstrb   <= '0;
        end else begin
            mem_we <= 1'b0;
            if (state == IDLE && awHs) begin
                idReg       <= axi.AWID;
                addrReg     <= axi.AWADDR;
                lenReg      <= axi.AWLEN;
                sizeReg     <= axi.AWSIZE;
                burstReg    <= axi.AWBURST;
                beatCnt     <= '0;
                errReg      <= illegalBurst;
                suppressReg <= illegalBurst;
            end
            if (state == DATA && wHs) begin
                mem_we    <= !suppressReg;
                mem_addr  <= addrReg;
                mem_wdata <= axi.WDATA;
                mem_wstrb <= axi.WSTRB;
                beatCnt   <= beatCnt + 8'd1;
                addrReg   <= nextAddr;
                if (axi.WLAST != countDone) begin
                    errReg <= 1'b1;
                end
            end
        end
    end

endmodule
